cv32e40p_ft_err_counter_bank: RTL and testbench



---
 rtl/cv32e40p_ft_err_counter_bank.sv | 147 ++++++++++++++
 tb/tb_cv32e40p_ft_err_counter_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_ft_err_counter_bank.sv
// Leaky-bucket error counters per (replica, operation class) for the fault-tolerant ALU.
// Replicas whose count reaches THRESHOLD are flagged for removal, limited by a per-class budget.
module cv32e40p_ft_err_counter_bank #(
   parameter int N_ALU       = 3,
   parameter int N_CLASS     = 14,
   parameter int CNT_W       = 7,
   parameter int INC         = 1,
   parameter int DEC         = 2,
   parameter int THRESHOLD   = 16,
   parameter int MAX_REMOVED = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         valid_i,
   input  logic [$clog2(N_CLASS)-1:0]   class_i,
   input  logic [N_ALU-1:0]             err_i,
   input  logic                         clear_i,
   input  logic [$clog2(N_ALU)-1:0]     rd_alu_i,
   input  logic [$clog2(N_CLASS)-1:0]   rd_class_i,
   output logic [CNT_W-1:0]             rd_cnt_o,
   output logic [N_ALU*N_CLASS-1:0]     remove_o,
   output logic                         any_remove_o,
   output logic                         budget_block_o
);

   localparam int CLS_W = $clog2(N_CLASS);
   localparam int ALU_W = $clog2(N_ALU);
   localparam int NB    = N_ALU * N_CLASS;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] THR_C   = CNT_W'(THRESHOLD);
   localparam logic [CNT_W:0]   INC_C   = (CNT_W + 1)'(INC);
   localparam logic [CNT_W:0]   DEC_C   = (CNT_W + 1)'(DEC);

   if (N_ALU < 2) begin : g_bad_alu
      $error("N_ALU must be at least 2");
   end
   if (THRESHOLD < 1 || THRESHOLD > (2 ** CNT_W) - 1) begin : g_bad_thr
      $error("THRESHOLD out of range 1..2^CNT_W-1");
   end
   if ((N_ALU > 2 && MAX_REMOVED > N_ALU - 2) || (N_ALU == 2 && MAX_REMOVED > 1)) begin : g_bad_budget
      $error("MAX_REMOVED would leave the voter without enough replicas");
   end

   logic [CNT_W-1:0] cnt_q [N_ALU][N_CLASS];
   logic [CNT_W-1:0] cnt_d [N_ALU][N_CLASS];
   logic [NB-1:0]    rem_q, rem_d;
   logic             block_q, block_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W:0] s;
      s = {1'b0, v} + INC_C;
      return (s > {1'b0, CNT_MAX}) ? CNT_MAX : s[CNT_W-1:0];
   endfunction

   function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
      logic [CNT_W:0] s;
      s = {1'b0, v} - DEC_C;
      return ({1'b0, v} < DEC_C) ? '0 : s[CNT_W-1:0];
   endfunction

   // An out-of-range class_i matches no loop index, so the operation is ignored.
   always_comb begin
      int               n_rem;
      int               n_grant;
      logic [CNT_W-1:0] nxt;
      // NOTE: every combinational output gets a default first so no latch is inferred.
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      block_d = 1'b0;
      n_rem   = 0;
      n_grant = 0;
      nxt     = '0;
      if (clear_i) begin
         for (int u = 0; u < N_ALU; u++) begin
            for (int c = 0; c < N_CLASS; c++) begin
               cnt_d[u][c] = '0;
            end
         end
         rem_d = '0;
      end else if (valid_i) begin
         for (int c = 0; c < N_CLASS; c++) begin
            if (class_i == CLS_W'(c)) begin
               n_rem = 0;
               for (int u = 0; u < N_ALU; u++) begin
                  n_rem += rem_q[u*N_CLASS + c] ? 1 : 0;
               end
               n_grant = 0;
               // Ascending scan gives the lowest index priority on a tie.
               for (int u = 0; u < N_ALU; u++) begin
                  if (!rem_q[u*N_CLASS + c]) begin
                     nxt         = err_i[u] ? sat_inc(cnt_q[u][c]) : sat_dec(cnt_q[u][c]);
                     cnt_d[u][c] = nxt;
                     if (nxt >= THR_C) begin
                        if (n_rem + n_grant < MAX_REMOVED) begin
                           rem_d[u*N_CLASS + c] = 1'b1;
                           n_grant++;
                        end else begin
                           block_d = 1'b1;
                        end
                     end
                  end
               end
            end
         end
      end
   end

   // Readout samples the pre-update state; unmatched selects fall through to zero.
   always_comb begin
      rd_cnt_d = '0;
      for (int u = 0; u < N_ALU; u++) begin
         for (int c = 0; c < N_CLASS; c++) begin
            if (rd_alu_i == ALU_W'(u) && rd_class_i == CLS_W'(c)) begin
               rd_cnt_d = cnt_q[u][c];
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the counter array is plain flops, not RAM, so it is reset like any register.
         for (int u = 0; u < N_ALU; u++) begin
            for (int c = 0; c < N_CLASS; c++) begin
               cnt_q[u][c] <= '0;
            end
         end
         rem_q    <= '0;
         block_q  <= 1'b0;
         rd_cnt_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         block_q  <= block_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   assign rd_cnt_o       = rd_cnt_q;
   assign remove_o       = rem_q;
   assign any_remove_o   = |rem_q;
   assign budget_block_o = block_q;

endmodule

// File: tb/tb_cv32e40p_ft_err_counter_bank.sv
// Self-checking bench: directed tables and sequences plus random traffic against an array model.
module tb_cv32e40p_ft_err_counter_bank;

   localparam int N_ALU = 3, N_CLASS = 14, CNT_W = 7;
   localparam int INC = 1, DEC = 2, THRESHOLD = 16, MAX_REMOVED = 1;
   localparam int CMAX = (1 << CNT_W) - 1;
   localparam int NB = N_ALU * N_CLASS;

   logic            clk = 1'b0;
   logic            rst, valid_i, clear_i;
   logic [3:0]      class_i, rd_class_i;
   logic [2:0]      err_i;
   logic [1:0]      rd_alu_i;
   logic [6:0]      rd_cnt_o;
   logic [NB-1:0]   remove_o;
   logic            any_remove_o, budget_block_o;

   always #5 clk = ~clk;

   cv32e40p_ft_err_counter_bank #(
      .N_ALU(N_ALU), .N_CLASS(N_CLASS), .CNT_W(CNT_W), .INC(INC), .DEC(DEC),
      .THRESHOLD(THRESHOLD), .MAX_REMOVED(MAX_REMOVED)
   ) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .class_i(class_i), .err_i(err_i),
      .clear_i(clear_i), .rd_alu_i(rd_alu_i), .rd_class_i(rd_class_i),
      .rd_cnt_o(rd_cnt_o), .remove_o(remove_o), .any_remove_o(any_remove_o),
      .budget_block_o(budget_block_o)
   );

   int m_cnt [N_ALU][N_CLASS];
   bit m_rem [N_ALU][N_CLASS];
   int exp_rd;
   bit exp_blk;
   int checks = 0, errors = 0;

   typedef struct {
      logic       v;
      logic [3:0] cls;
      logic [2:0] err;
      logic [6:0] exp_rd;
   } vec_t;
   vec_t leak [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NB-1:0] model_flags();
      logic [NB-1:0] f;
      f = '0;
      for (int u = 0; u < N_ALU; u++)
         for (int c = 0; c < N_CLASS; c++)
            f[u*N_CLASS + c] = m_rem[u][c];
      return f;
   endfunction

   task automatic model_zero();
      for (int u = 0; u < N_ALU; u++)
         for (int c = 0; c < N_CLASS; c++) begin
            m_cnt[u][c] = 0;
            m_rem[u][c] = 0;
         end
   endtask

   // Applies the current inputs to the model as one clock edge.
   task automatic model_edge();
      int ra, rc;
      ra = int'(rd_alu_i);
      rc = int'(rd_class_i);
      exp_rd  = (ra < N_ALU && rc < N_CLASS) ? m_cnt[ra][rc] : 0;
      exp_blk = 0;
      if (rst) begin
         exp_rd = 0;
         model_zero();
      end else if (clear_i) begin
         model_zero();
      end else if (valid_i && int'(class_i) < N_CLASS) begin
         int c, removed, granted;
         c = int'(class_i);
         removed = 0;
         granted = 0;
         for (int u = 0; u < N_ALU; u++) removed += m_rem[u][c] ? 1 : 0;
         for (int u = 0; u < N_ALU; u++) begin
            if (!m_rem[u][c]) begin
               int v;
               v = m_cnt[u][c];
               if (err_i[u]) v = (v + INC > CMAX) ? CMAX : v + INC;
               else          v = (v < DEC) ? 0 : v - DEC;
               m_cnt[u][c] = v;
               if (v >= THRESHOLD) begin
                  if (removed + granted < MAX_REMOVED) begin
                     m_rem[u][c] = 1;
                     granted++;
                  end else begin
                     exp_blk = 1;
                  end
               end
            end
         end
      end
   endtask

   task automatic step(input string tag);
      logic [NB-1:0] f;
      model_edge();
      @(posedge clk);
      #1;
      f = model_flags();
      check({tag, " rd_cnt"}, 64'(rd_cnt_o), 64'(exp_rd));
      check({tag, " remove"}, 64'(remove_o), 64'(f));
      check({tag, " any"}, 64'(any_remove_o), 64'(|f));
      check({tag, " block"}, 64'(budget_block_o), 64'(exp_blk));
   endtask

   task automatic drive(input logic v, input logic [3:0] cls, input logic [2:0] err,
                        input logic clr);
      valid_i = v;
      class_i = cls;
      err_i   = err;
      clear_i = clr;
   endtask

   // Walks every readout address, including out-of-range ones, with no updates.
   task automatic scan(input string tag);
      drive(1'b0, 4'd0, 3'b000, 1'b0);
      for (int a = 0; a < 4; a++)
         for (int c = 0; c < 16; c++) begin
            rd_alu_i   = 2'(a);
            rd_class_i = 4'(c);
            step(tag);
         end
   endtask

   initial begin
      logic [NB-1:0] saved;
      model_zero();
      rst = 1'b1;
      rd_alu_i = 2'd0;
      rd_class_i = 4'd0;
      drive(1'b1, 4'd0, 3'b111, 1'b0);
      step("reset");
      step("reset");
      check("reset rd_cnt zero", 64'(rd_cnt_o), 64'd0);
      check("reset remove zero", 64'(remove_o), 64'd0);
      rst = 1'b0;
      scan("reset scan");

      // Leak: five errors on unit1 class0, then four clean ops, then idle.
      for (int i = 0; i < 5; i++) leak[i] = '{1'b1, 4'd0, 3'b010, 7'(i)};
      leak[5] = '{1'b1, 4'd0, 3'b000, 7'd5};
      leak[6] = '{1'b1, 4'd0, 3'b000, 7'd3};
      leak[7] = '{1'b1, 4'd0, 3'b000, 7'd1};
      leak[8] = '{1'b1, 4'd0, 3'b000, 7'd0};
      leak[9] = '{1'b0, 4'd0, 3'b000, 7'd0};
      rd_alu_i = 2'd1;
      rd_class_i = 4'd0;
      for (int i = 0; i < 10; i++) begin
         drive(leak[i].v, leak[i].cls, leak[i].err, 1'b0);
         step("leak");
         check("leak table rd", 64'(rd_cnt_o), 64'(leak[i].exp_rd));
      end

      // Threshold on unit0 class3, then a frozen 17th error.
      rd_alu_i = 2'd0;
      rd_class_i = 4'd3;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 4'd3, 3'b001, 1'b0);
         step("thr");
      end
      check("thr remove bit", 64'(remove_o[0*N_CLASS + 3]), 64'd1);
      check("thr any", 64'(any_remove_o), 64'd1);
      step("thr frozen");
      drive(1'b0, 4'd0, 3'b000, 1'b0);
      step("thr read");
      check("thr rd 16", 64'(rd_cnt_o), 64'd16);
      check("thr rd 16 after extra", 64'(rd_cnt_o), 64'd16);

      // Budget tie on class7: unit0 wins, unit2 refused and saturates.
      rd_alu_i = 2'd2;
      rd_class_i = 4'd7;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 4'd7, 3'b101, 1'b0);
         step("tie");
      end
      check("tie block pulse", 64'(budget_block_o), 64'd1);
      check("tie unit0 removed", 64'(remove_o[0*N_CLASS + 7]), 64'd1);
      check("tie unit2 kept", 64'(remove_o[2*N_CLASS + 7]), 64'd0);
      drive(1'b0, 4'd0, 3'b000, 1'b0);
      step("tie idle");
      check("tie block one cycle", 64'(budget_block_o), 64'd0);
      for (int i = 0; i < 120; i++) begin
         drive(1'b1, 4'd7, 3'b100, 1'b0);
         step("sat");
         check("sat block each error", 64'(budget_block_o), 64'd1);
      end
      drive(1'b0, 4'd0, 3'b000, 1'b0);
      step("sat read");
      check("sat rd 127", 64'(rd_cnt_o), 64'd127);
      check("sat unit2 kept", 64'(remove_o[2*N_CLASS + 7]), 64'd0);

      // Out-of-range class leaves all state unchanged.
      saved = remove_o;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, (i % 2 == 0) ? 4'd14 : 4'd15, 3'b111, 1'b0);
         step("badcls");
      end
      check("badcls flags held", 64'(remove_o), 64'(saved));
      scan("badcls scan");

      // Clear wins over a simultaneous update.
      drive(1'b1, 4'd7, 3'b111, 1'b1);
      step("clear");
      check("clear remove zero", 64'(remove_o), 64'd0);
      check("clear any zero", 64'(any_remove_o), 64'd0);
      scan("clear scan");

      // Random traffic with occasional clear and mid-stream reset.
      for (int i = 0; i < 3000; i++) begin
         rst     = ($urandom_range(0, 499) == 0);
         clear_i = ($urandom_range(0, 299) == 0);
         valid_i = ($urandom_range(0, 9) < 8);
         class_i = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(14, 15))
                                               : 4'($urandom_range(0, 2));
         for (int u = 0; u < N_ALU; u++) err_i[u] = ($urandom_range(0, 99) < 75);
         rd_alu_i   = 2'($urandom_range(0, 3));
         rd_class_i = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : class_i;
         step("rand");
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
